tsc_mc_core: RTL and testbench

Multi-cycle TSC processor core, the parametrised successor to the single-cycle TSC CPU. It fetches 16-bit TSC instructions from an external instruction memory over a valid/request handshake, so it is no longer limited to a fixed built-in program. Instructions execute through a FETCH/EXEC/WB state machine with a bounded program range, halt detection and an instruction counter. The WWD/register-view output logic is kept compatible with the board-level output logic.

---
 rtl/tsc_mc_core_if.sv | 13 +
 rtl/tsc_mc_core.sv | 195 +++++++++++++++++++
 tb/tb_tsc_mc_core.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tsc_mc_core_if.sv
// tsc_mc_core_if: instruction-fetch handshake between the TSC core (master)
// and an external instruction memory (slave).
interface tsc_mc_core_if #(
    parameter int WORD_SIZE = 16
);
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic                 i_valid;
    logic [15:0]          i_data;

    modport master (output i_req, output i_addr, input i_valid, input i_data);
    modport slave  (input i_req, input i_addr, output i_valid, output i_data);
endinterface

// File: rtl/tsc_mc_core.sv
// tsc_mc_core: multi-cycle TSC core (FETCH/EXEC/WB/HALT) fetching from external memory.
// Define TSC_BRANCH_EN to add BNE/BEQ/BGZ/BLZ; otherwise ops 0-3 retire as NOPs.
module tsc_mc_core #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] PC_LIMIT  = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_enable,
    tsc_mc_core_if.master        ibus,
    input  logic                 wwd_enable,
    input  logic [1:0]           register_selection,
    output logic [WORD_SIZE-1:0] output_port,
    output logic                 output_valid,
    output logic [15:0]          num_inst,
    output logic [7:0]           pc_low8,
    output logic                 halted
);
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

    localparam logic [3:0] OP_RTYPE = 4'hF;
    localparam logic [3:0] OP_ADI   = 4'h4;
    localparam logic [3:0] OP_LHI   = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [5:0] FN_ADD   = 6'd0;
    localparam logic [5:0] FN_WWD   = 6'd28;

    state_t                    state_q, state_d;
    logic [WORD_SIZE-1:0]      pc_q, pc_d;
    logic [WORD_SIZE-1:0]      npc_q, npc_d;
    logic [WORD_SIZE-1:0]      res_q, res_d;
    logic [WORD_SIZE-1:0]      outp_q, outp_d;
    logic [3:0][WORD_SIZE-1:0] rf_q, rf_d;
    logic [15:0]               ir_q, ir_d;
    logic [15:0]               ni_q, ni_d;
    logic [1:0]                wa_q, wa_d;
    logic                      wen_q, wen_d;
    logic                      wwd_q, wwd_d;
    logic                      outv_q, outv_d;
    logic                      halted_q, halted_d;

    logic [3:0]           op;
    logic [1:0]           rs, rt, rd;
    logic [5:0]           func;
    logic [7:0]           imm8;
    logic [11:0]          target;
    logic [WORD_SIZE-1:0] rs_v, rt_v, simm, pc_inc;

    assign op     = ir_q[15:12];
    assign rs     = ir_q[11:10];
    assign rt     = ir_q[9:8];
    assign rd     = ir_q[7:6];
    assign func   = ir_q[5:0];
    assign imm8   = ir_q[7:0];
    assign target = ir_q[11:0];
    assign rs_v   = rf_q[rs];
    assign rt_v   = rf_q[rt];
    assign simm   = {{(WORD_SIZE-8){imm8[7]}}, imm8};
    assign pc_inc = pc_q + WORD_SIZE'(1);

`ifdef TSC_BRANCH_EN
    logic [WORD_SIZE-1:0] br_tgt;
    logic                 rs_pos, rs_neg;
    assign br_tgt = pc_inc + simm;
    assign rs_neg = rs_v[WORD_SIZE-1];
    assign rs_pos = ~rs_v[WORD_SIZE-1] & (|rs_v);
`endif

    // Reset is folded into i_req so a fetch in flight is dropped in the reset cycle.
    assign ibus.i_req  = (state_q == S_FETCH) & cpu_enable & ~reset;
    assign ibus.i_addr = pc_q;
    assign output_port  = outp_q;
    assign output_valid = outv_q;
    assign num_inst     = ni_q;
    assign pc_low8      = pc_q[7:0];
    assign halted       = halted_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_d     = rf_q;
        ni_d     = ni_q;
        npc_d    = npc_q;
        res_d    = res_q;
        wa_d     = wa_q;
        wen_d    = wen_q;
        wwd_d    = wwd_q;
        halted_d = halted_q;
        if (cpu_enable) begin
            case (state_q)
                S_FETCH: begin
                    if (ibus.i_valid) begin
                        ir_d    = ibus.i_data;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    npc_d   = pc_inc;
                    res_d   = '0;
                    wa_d    = rt;
                    wen_d   = 1'b0;
                    wwd_d   = 1'b0;
                    state_d = S_WB;
                    case (op)
                        OP_RTYPE: begin
                            if (func == FN_ADD) begin
                                res_d = rs_v + rt_v;
                                wa_d  = rd;
                                wen_d = 1'b1;
                            end else if (func == FN_WWD) begin
                                res_d = rs_v;
                                wwd_d = 1'b1;
                            end
                        end
                        OP_ADI: begin
                            res_d = rs_v + simm;
                            wen_d = 1'b1;
                        end
                        OP_LHI: begin
                            res_d = WORD_SIZE'({imm8, 8'h00});
                            wen_d = 1'b1;
                        end
                        OP_JMP: npc_d = {pc_q[WORD_SIZE-1:12], target};
`ifdef TSC_BRANCH_EN
                        4'h0: if (rs_v != rt_v) npc_d = br_tgt;
                        4'h1: if (rs_v == rt_v) npc_d = br_tgt;
                        4'h2: if (rs_pos)       npc_d = br_tgt;
                        4'h3: if (rs_neg)       npc_d = br_tgt;
`endif
                        default: ;
                    endcase
                end
                S_WB: begin
                    if (wen_q) rf_d[wa_q] = res_q;
                    pc_d = npc_q;
                    ni_d = ni_q + 16'd1;
                    // Halt is keyed on the PC of the instruction just retired.
                    if (pc_q == PC_LIMIT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d  = S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // Mirror runs every cycle, independent of cpu_enable and HALT.
    always_comb begin
        outv_d = 1'b0;
        outp_d = outp_q;
        if (!wwd_enable) begin
            outp_d = rf_q[register_selection];
        end else if (state_q == S_WB && cpu_enable && wwd_q) begin
            outp_d = res_q;
            outv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            rf_q     <= '0;
            ni_q     <= '0;
            npc_q    <= '0;
            res_q    <= '0;
            wa_q     <= '0;
            wen_q    <= 1'b0;
            wwd_q    <= 1'b0;
            outp_q   <= '0;
            outv_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            rf_q     <= rf_d;
            ni_q     <= ni_d;
            npc_q    <= npc_d;
            res_q    <= res_d;
            wa_q     <= wa_d;
            wen_q    <= wen_d;
            wwd_q    <= wwd_d;
            outp_q   <= outp_d;
            outv_q   <= outv_d;
            halted_q <= halted_d;
        end
    end
endmodule

// File: tb/tb_tsc_mc_core.sv
// tb_tsc_mc_core: random instruction stream checked against an ISA-level model,
// plus a second instance with PC_LIMIT=3 for halt behaviour.
module tb_tsc_mc_core;
    logic        clk = 1'b0;
    logic        reset, cpu_enable, wwd_enable;
    logic [1:0]  register_selection;
    logic [15:0] output_port, num_inst;
    logic        output_valid, halted;
    logic [7:0]  pc_low8;

    logic        h_reset, h_en, h_wwd;
    logic [1:0]  h_sel;
    logic [15:0] h_out, h_ni;
    logic        h_ov, h_halted;
    logic [7:0]  h_pcl;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_rf [4];
    logic [15:0] m_pc, m_ni, m_out;

    always #5 clk = ~clk;

    tsc_mc_core_if #(.WORD_SIZE(16)) ibus ();
    tsc_mc_core_if #(.WORD_SIZE(16)) ibus_h ();

    tsc_mc_core #(.WORD_SIZE(16), .RESET_PC(16'h0000), .PC_LIMIT(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .cpu_enable(cpu_enable), .ibus(ibus),
        .wwd_enable(wwd_enable), .register_selection(register_selection),
        .output_port(output_port), .output_valid(output_valid), .num_inst(num_inst),
        .pc_low8(pc_low8), .halted(halted)
    );

    tsc_mc_core #(.WORD_SIZE(16), .RESET_PC(16'h0000), .PC_LIMIT(16'h0003)) dut_h (
        .clk(clk), .reset(h_reset), .cpu_enable(h_en), .ibus(ibus_h),
        .wwd_enable(h_wwd), .register_selection(h_sel),
        .output_port(h_out), .output_valid(h_ov), .num_inst(h_ni),
        .pc_low8(h_pcl), .halted(h_halted)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; cpu_enable = 1'b1;
        ibus.i_valid = 1'b1; ibus.i_data = 16'h6155;
        #1;
        chk("rst_req", 32'(ibus.i_req), 32'd0);
        tick();
        chk("rst_req_edge", 32'(ibus.i_req), 32'd0);
        reset = 1'b0; ibus.i_valid = 1'b0;
        for (int i = 0; i < 4; i++) m_rf[i] = 16'h0;
        m_pc = 16'h0; m_ni = 16'h0; m_out = 16'h0;
        #1;
        chk("rst_ni", 32'(num_inst), 32'd0);
        chk("rst_out", 32'(output_port), 32'd0);
        chk("rst_ov", 32'(output_valid), 32'd0);
        chk("rst_halt", 32'(halted), 32'd0);
        chk("rst_addr", 32'(ibus.i_addr), 32'd0);
        chk("rst_req_after", 32'(ibus.i_req), 32'd1);
    endtask

    // Fetch with wait/disabled cycles, execute, retire; then compare against the ISA model.
    task automatic run_instr(input logic [15:0] ins, input int waits, input int dis_f,
                             input int dis_e, input logic wen, input logic [1:0] sel);
        logic [15:0] rsv, rtv, sx, npc, eo;
        logic        wwd;
        wwd_enable = wen; register_selection = sel;
        chk("fetch_req", 32'(ibus.i_req), 32'd1);
        chk("fetch_addr", 32'(ibus.i_addr), 32'(m_pc));
        repeat (waits) begin
            ibus.i_valid = 1'b0; ibus.i_data = 16'($urandom);
            tick();
            chk("wait_req", 32'(ibus.i_req), 32'd1);
        end
        repeat (dis_f) begin
            cpu_enable = 1'b0; ibus.i_valid = 1'b1;
            ibus.i_data = {4'h6, 2'b00, 2'($urandom), 8'hA5};
            #1;
            chk("disf_req", 32'(ibus.i_req), 32'd0);
            tick();
        end
        cpu_enable = 1'b1;
        ibus.i_valid = 1'b1; ibus.i_data = ins;
        tick();
        ibus.i_valid = 1'($urandom); ibus.i_data = 16'($urandom);
        chk("exec_req", 32'(ibus.i_req), 32'd0);
        repeat (dis_e) begin
            cpu_enable = 1'b0;
            tick();
            chk("dise_ni", 32'(num_inst), 32'(m_ni));
            chk("dise_req", 32'(ibus.i_req), 32'd0);
        end
        cpu_enable = 1'b1;
        tick();
        chk("wb_ni", 32'(num_inst), 32'(m_ni));

        rsv = m_rf[ins[11:10]]; rtv = m_rf[ins[9:8]];
        sx  = {{8{ins[7]}}, ins[7:0]};
        npc = m_pc + 16'd1; wwd = 1'b0;
        eo  = wen ? m_out : m_rf[sel];
        case (ins[15:12])
            4'hF: if (ins[5:0] == 6'd0) m_rf[ins[7:6]] = rsv + rtv;
                  else if (ins[5:0] == 6'd28) wwd = 1'b1;
            4'h4: m_rf[ins[9:8]] = rsv + sx;
            4'h6: m_rf[ins[9:8]] = {ins[7:0], 8'h00};
            4'h9: npc = {m_pc[15:12], ins[11:0]};
`ifdef TSC_BRANCH_EN
            4'h0: if (rsv != rtv) npc = m_pc + 16'd1 + sx;
            4'h1: if (rsv == rtv) npc = m_pc + 16'd1 + sx;
            4'h2: if ($signed(rsv) > 0) npc = m_pc + 16'd1 + sx;
            4'h3: if ($signed(rsv) < 0) npc = m_pc + 16'd1 + sx;
`endif
            default: ;
        endcase
        if (wen && wwd) eo = rsv;
        m_pc = npc; m_ni = m_ni + 16'd1; m_out = eo;

        tick();
        ibus.i_valid = 1'b0;
        chk("ret_ni", 32'(num_inst), 32'(m_ni));
        chk("ret_addr", 32'(ibus.i_addr), 32'(m_pc));
        chk("ret_pcl", 32'(pc_low8), 32'(m_pc[7:0]));
        chk("ret_ov", 32'(output_valid), 32'(wen && wwd));
        chk("ret_out", 32'(output_port), 32'(m_out));
        chk("ret_halt", 32'(halted), 32'd0);
    endtask

    function automatic logic [15:0] rand_ins();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 8))
            0: return {4'hF, r[11:6], 6'd0};
            1: return {4'hF, r[11:10], 4'h0, 6'd28};
            2: return {4'h4, r[11:0]};
            3: return {4'h6, r[11:0]};
            4: return {4'h9, r[11:0]};
            5: return {2'b00, r[13:0]};
            6: return {4'hF, r[11:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; cpu_enable = 1'b1; wwd_enable = 1'b0; register_selection = 2'd0;
        ibus.i_valid = 1'b0; ibus.i_data = 16'h0;
        h_reset = 1'b1; h_en = 1'b1; h_wwd = 1'b0; h_sel = 2'd0;
        ibus_h.i_valid = 1'b1; ibus_h.i_data = 16'h7000;

        do_reset();
        // LHI r1, 0x01 with zero-wait memory
        run_instr(16'h6101, 0, 0, 0, 1'b0, 2'd1);
        chk("lhi_addr", 32'(ibus.i_addr), 32'h1);
        chk("lhi_ni", 32'(num_inst), 32'd1);
        // ADI r3 = r1 - 4, then WWD r3 visible on the port
        run_instr(16'h47FC, 0, 0, 0, 1'b1, 2'd0);
        run_instr(16'hFC1C, 0, 0, 0, 1'b1, 2'd0);
        chk("wwd_out", 32'(output_port), 32'h00FC);
        chk("wwd_pulse", 32'(output_valid), 32'd1);
        tick();
        chk("wwd_pulse_end", 32'(output_valid), 32'd0);
        chk("wwd_hold", 32'(output_port), 32'h00FC);
        run_instr(16'hFC1C, 0, 0, 0, 1'b0, 2'd3);
        chk("mirror_out", 32'(output_port), 32'h00FC);
        chk("mirror_nopulse", 32'(output_valid), 32'd0);
        // JMP into 0x10, then JMP from 0x10 to 0x15
        run_instr(16'h9010, 0, 0, 0, 1'b0, 2'd0);
        chk("jmp1_addr", 32'(ibus.i_addr), 32'h0010);
        run_instr(16'h9015, 1, 0, 0, 1'b0, 2'd0);
        chk("jmp2_addr", 32'(ibus.i_addr), 32'h0015);
        chk("jmp2_ni", 32'(num_inst), 32'd6);
        // Two wait cycles plus three disabled EXEC cycles: eight cycles in all
        run_instr(16'h7000, 2, 0, 3, 1'b1, 2'd0);
        chk("slow_ni", 32'(num_inst), 32'd7);

        // Branch scenario: r0=1, r1=2, BNE at PC 5
        do_reset();
        run_instr(16'h4001, 0, 0, 0, 1'b0, 2'd0);
        run_instr(16'h4502, 0, 0, 0, 1'b0, 2'd1);
        repeat (3) run_instr(16'h7000, 0, 0, 0, 1'b0, 2'd0);
        chk("bne_pc", 32'(ibus.i_addr), 32'h0005);
        run_instr(16'h0102, 0, 0, 0, 1'b0, 2'd0);
`ifdef TSC_BRANCH_EN
        chk("bne_next", 32'(ibus.i_addr), 32'h0008);
`else
        chk("bne_next", 32'(ibus.i_addr), 32'h0006);
`endif
        chk("bne_ni", 32'(num_inst), 32'd6);

        // Reset while a fetch is pending
        ibus.i_valid = 1'b0;
        tick();
        do_reset();

        for (int k = 0; k < 160; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                tick();
                do_reset();
            end
            run_instr(rand_ins(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 5) == 0) ? 1 : 0,
                      ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0,
                      1'($urandom), 2'($urandom));
        end

        // Halt instance: PC_LIMIT=3, stream of NOPs from zero-wait memory
        tick();
        chk("h_rst_req", 32'(ibus_h.i_req), 32'd0);
        h_reset = 1'b0;
        n = 0;
        while (!h_halted && n < 40) begin
            tick();
            n++;
        end
        chk("h_cycles", 32'(n), 32'd12);
        chk("h_ni", 32'(h_ni), 32'd4);
        chk("h_pcl", 32'(h_pcl), 32'd4);
        repeat (3) begin
            tick();
            chk("h_req_idle", 32'(ibus_h.i_req), 32'd0);
            chk("h_stay", 32'(h_halted), 32'd1);
        end
        h_reset = 1'b1;
        tick();
        chk("h_rst_halt", 32'(h_halted), 32'd0);
        chk("h_rst_pc", 32'(h_pcl), 32'd0);
        h_reset = 1'b0;
        #1;
        chk("h_rst_req", 32'(ibus_h.i_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
